// File: rtl/mem_responder.sv
// Fixed-latency word memory responder with IDLE/BUSY/DONE handshake and 4-byte lanes.
// Optional MEM_RESPONDER_ALIGN_CHECK_EN flags misaligned starts via sticky mem_err.
module mem_responder #(
  parameter int XLEN      = 32,
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [7:0]      mem_data_in  [0:3],
  input  logic            mem_write_en,
  output logic [7:0]      mem_data_out [0:3],
  output logic            mem_ready,
  output logic            mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS-1:0] key_q, key_d;
  logic                 key_vld_q, key_vld_d;
  logic                 wr_q, wr_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic [7:0]           wdata_q [0:3];
  logic [7:0]           wdata_d [0:3];
  logic [7:0]           rdata_q [0:3];
  logic [7:0]           rdata_d [0:3];

  logic [ADDR_BITS-1:0] word_base;
  logic                 start;
  logic                 misaligned;
  logic                 commit_wr;
  logic                 unused_addr;

  // Backing store: never reset, contents survive rst_b.
  logic [7:0] mem_q [0:(1<<ADDR_BITS)-1];

  assign word_base = {mem_addr[ADDR_BITS-1:2], 2'b00};
  // Writes always start; reads only when the word differs from the last completed read.
  assign start     = mem_write_en || !key_vld_q || (word_base != key_q);
  assign commit_wr = (state_q == BUSY) && (cnt_q == '0) && wr_q;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign misaligned  = |mem_addr[1:0];
  assign mem_err     = err_q;
  assign unused_addr = ^mem_addr[XLEN-1:ADDR_BITS];
`else
  assign misaligned  = 1'b0;
  assign mem_err     = 1'b0;
  assign unused_addr = ^{mem_addr[XLEN-1:ADDR_BITS], mem_addr[1:0], err_q};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    key_d     = key_q;
    key_vld_d = key_vld_q;
    wr_d      = wr_q;
    ready_d   = 1'b0;
    err_d     = err_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = word_base;
          wdata_d = mem_data_in;
          wr_d    = mem_write_en;
          if (misaligned) begin
            err_d     = 1'b1;
            key_vld_d = 1'b0;
            cnt_d     = '0;
            ready_d   = 1'b1;
            state_d   = DONE;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          state_d = DONE;
          if (wr_q) begin
            key_vld_d = 1'b0;
          end else begin
            key_vld_d = 1'b1;
            key_d     = addr_q;
            for (int unsigned k = 0; k < 4; k++) begin
              rdata_d[k] = mem_q[addr_q + ADDR_BITS'(k)];
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      key_q     <= '0;
      key_vld_q <= 1'b0;
      wr_q      <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '{default: '0};
      rdata_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      key_q     <= key_d;
      key_vld_q <= key_vld_d;
      wr_q      <= wr_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // An async reset forces state_q to IDLE, so an aborted access never reaches commit.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      for (int unsigned k = 0; k < 4; k++) begin
        mem_q[addr_q + ADDR_BITS'(k)] <= wdata_q[k];
      end
    end
  end

  assign mem_data_out = rdata_q;
  assign mem_ready    = ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table-driven accesses with a scoreboard on
// completion, plus hand sequences for reset abort, input change, alignment and LATENCY=1.
module tb_mem_responder;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  always #5 clk = ~clk;

  logic [31:0] addr0, addr1;
  logic [7:0]  din0  [0:3];
  logic [7:0]  din1  [0:3];
  logic [7:0]  dout0 [0:3];
  logic [7:0]  dout1 [0:3];
  logic        we0, we1, rdy0, rdy1, err0, err1;

  mem_responder #(.XLEN(32), .ADDR_BITS(16), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_b(rst_b), .mem_addr(addr0), .mem_data_in(din0),
    .mem_write_en(we0), .mem_data_out(dout0), .mem_ready(rdy0), .mem_err(err0));

  mem_responder #(.XLEN(32), .ADDR_BITS(16), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_b(rst_b), .mem_addr(addr1), .mem_data_in(din1),
    .mem_write_en(we1), .mem_data_out(dout1), .mem_ready(rdy1), .mem_err(err1));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  logic exp_err = 1'b0;

  function automatic logic [31:0] pack4(input logic [7:0] b [0:3]);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every completion pulse on the main instance consumes one expectation.
  always @(negedge clk) begin
    if (rst_b && rdy0) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ready: got ready with empty scoreboard, expected none");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_data"}, pack4(dout0), e.data);
        check({e.name, "_err"}, {31'b0, err0}, {31'b0, e.err});
      end
    end
  end

  task automatic drive0(input bit we, input logic [31:0] a, input logic [31:0] d);
    we0 = we;
    addr0 = a;
    din0[0] = d[31:24]; din0[1] = d[23:16]; din0[2] = d[15:8]; din0[3] = d[7:0];
  endtask

  task automatic drive1(input bit we, input logic [31:0] a, input logic [31:0] d);
    we1 = we;
    addr1 = a;
    din1[0] = d[31:24]; din1[1] = d[23:16]; din1[2] = d[15:8]; din1[3] = d[7:0];
  endtask

  task automatic wait_rdy0(input int exp_n, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy0 && n < 50);
    check({name, "_latency"}, n, exp_n);
  endtask

  task automatic wait_rdy1(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy1 && n < 50);
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge after DONE.
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input int lat, input string name);
    exp_t e;
    drive0(we, a, d);
    e.data = exp; e.err = exp_err; e.name = name;
    sb_q.push_back(e);
    wait_rdy0(lat + 1, name);
    @(negedge clk);
    check({name, "_ready_width"}, {31'b0, rdy0}, 32'd0);
  endtask

  initial begin
    int n;
    exp_t e;

    tbl[0] = '{1'b1, 32'h0000_0100, 32'h1122_3344, 32'h0000_0000};
    tbl[1] = '{1'b0, 32'h0000_0100, 32'h0,         32'h1122_3344};
    tbl[2] = '{1'b1, 32'h0001_0100, 32'hAABB_CCDD, 32'h1122_3344};
    tbl[3] = '{1'b0, 32'h0000_0100, 32'h0,         32'hAABB_CCDD};
    tbl[4] = '{1'b1, 32'h0000_0200, 32'h0102_0304, 32'hAABB_CCDD};
    tbl[5] = '{1'b1, 32'h0000_0300, 32'h0506_0708, 32'hAABB_CCDD};
    tbl[6] = '{1'b1, 32'h0000_0400, 32'hCAFE_F00D, 32'hAABB_CCDD};
    tbl[7] = '{1'b0, 32'h0000_0400, 32'h0,         32'hCAFE_F00D};
    tbl[8] = '{1'b0, 32'h0000_0200, 32'h0,         32'h0102_0304};
    tbl[9] = '{1'b0, 32'h0001_0300, 32'h0,         32'h0506_0708};

    rst_b = 1'b0;
    drive0(1'b1, tbl[0].addr, tbl[0].data);
    drive1(1'b1, 32'h0, 32'h0A0B_0C0D);
    #1;
    check("reset_ready", {31'b0, rdy0}, 32'd0);
    check("reset_data", pack4(dout0), 32'd0);
    check("reset_err", {31'b0, err0}, 32'd0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < 10; i++) begin
      access(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].exp, LAT, $sformatf("tbl%0d", i));
    end

    // Reset two cycles into a write to 0x400 aborts it.
    drive0(1'b1, 32'h400, 32'h1234_5678);
    repeat (2) @(negedge clk);
    #1 rst_b = 1'b0;
    #1;
    check("abort_ready", {31'b0, rdy0}, 32'd0);
    check("abort_data", pack4(dout0), 32'd0);
    check("abort_err", {31'b0, err0}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    access(1'b0, 32'h400, 32'h0, 32'hCAFE_F00D, LAT, "after_abort_rd400");

    // Address change one cycle after capture is ignored; 0x300 follows after DONE->IDLE.
    drive0(1'b0, 32'h200, 32'h0);
    e.data = 32'h0102_0304; e.err = 1'b0; e.name = "rd200_held";
    sb_q.push_back(e);
    @(negedge clk);
    addr0 = 32'h300;
    e.data = 32'h0506_0708; e.err = 1'b0; e.name = "rd300_next";
    sb_q.push_back(e);
    wait_rdy0(LAT, "rd200_held");
    wait_rdy0(LAT + 2, "rd300_next");
    @(negedge clk);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    exp_err = 1'b1;
    access(1'b1, 32'h102, 32'h5566_7788, 32'h0506_0708, 0, "misaligned_wr");
    access(1'b0, 32'h100, 32'h0, 32'hAABB_CCDD, LAT, "rd100_after_mis");
`else
    access(1'b1, 32'h102, 32'h5566_7788, 32'h0506_0708, LAT, "unaligned_wr");
    access(1'b0, 32'h100, 32'h0, 32'h5566_7788, LAT, "rd100_after_unal");
`endif
    check("scoreboard_drain", sb_q.size(), 32'd0);

    // LATENCY=1 instance: held write re-executes, then back-to-back reads.
    wait_rdy1(n);
    wait_rdy1(n);
    check("l1_held_write_period", n, 32'd3);
    drive1(1'b1, 32'h4, 32'h1A1B_1C1D);
    wait_rdy1(n);
    check("l1_wr4_spacing", n, 32'd3);
    drive1(1'b0, 32'h0, 32'h0);
    wait_rdy1(n);
    check("l1_rd0_spacing", n, 32'd3);
    check("l1_rd0_data", pack4(dout1), 32'h0A0B_0C0D);
    drive1(1'b0, 32'h4, 32'h0);
    wait_rdy1(n);
    check("l1_b2b_spacing", n, 32'd3);
    check("l1_rd4_data", pack4(dout1), 32'h1A1B_1C1D);
    @(negedge clk);
    check("l1_ready_width", {31'b0, rdy1}, 32'd0);
    repeat (2) @(negedge clk);
    check("l1_same_key_idle", {31'b0, rdy1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
